// File: rtl/dma_mm2s_burst_scheduler.sv
// MM2S burst scheduler: splits one (address, byte count) command into AXI4 INCR read bursts.
// Optional macro DMA_SCHED_RRESP_ERR_EN: sticky err on SLVERR/DECERR, which also stops further AR issue.
module dma_mm2s_burst_scheduler #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BTT_WIDTH       = 23,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [BTT_WIDTH-1:0]  cmd_btt,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    input  logic                  m_axi_rlast,
    input  logic [1:0]            m_axi_rresp,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // ISSUE | presenting AR bursts, throttled by the outstanding count
    // DRAIN | no more bursts to issue, waiting for rlast retires
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int BPB   = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BPB);
    localparam int OUT_W = 4;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SIZE;

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BTT_WIDTH-1:0]   rem_q;
    logic [OUT_W-1:0]       out_q;
    logic [OUT_W-1:0]       out_d;
    logic                   err_q;
    logic                   abort;

    logic                   cmd_accept;
    logic                   ar_hs;
    logic                   r_hs;
    logic                   retire;
    logic [BTT_WIDTH:0]     btt_round;
    logic [BTT_WIDTH-1:0]   total_beats;
    logic [12:0]            page_bytes;
    logic [12:0]            page_beats;
    logic [12:0]            rem_cap;
    logic [12:0]            burst_len;
    logic                   last_burst;

    assign cmd_accept = cmd_valid & cmd_ready;
    assign ar_hs      = m_axi_arvalid & m_axi_arready;
    assign r_hs       = m_axi_rvalid & m_axi_rready;
    // A retire seen with nothing outstanding (stale beats after reset) is dropped.
    assign retire     = r_hs & m_axi_rlast & (out_q != '0);

    assign btt_round   = {1'b0, cmd_btt} + (BTT_WIDTH+1)'(BPB - 1);
    assign total_beats = BTT_WIDTH'(btt_round >> SIZE);

    assign page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    assign page_beats = page_bytes >> SIZE;
    assign rem_cap    = (rem_q > BTT_WIDTH'(MAX_BURST_LEN)) ? 13'(MAX_BURST_LEN) : 13'(rem_q);
    assign burst_len  = (page_beats < rem_cap) ? page_beats : rem_cap;
    assign last_burst = (rem_q == BTT_WIDTH'(burst_len));

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = (burst_len == 13'd0) ? 8'd0 : 8'(burst_len - 13'd1);
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;

`ifdef DMA_SCHED_RRESP_ERR_EN
    logic bad_hs;

    assign bad_hs = r_hs & m_axi_rresp[1];
    // Abort reacts to the failing beat itself so done timing matches a normal drain.
    assign abort  = err_q | bad_hs;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else if (cmd_accept) begin
            err_q <= 1'b0;
        end else if (bad_hs) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_rresp;

    assign unused_rresp = ^m_axi_rresp;
    assign abort        = 1'b0;
    assign err_q        = 1'b0;
`endif

    assign err = err_q;

    always_comb begin
        out_d = out_q;
        if (ar_hs && !retire) begin
            out_d = out_q + OUT_W'(1);
        end else if (!ar_hs && retire) begin
            out_d = out_q - OUT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q <= '0;
            rem_q  <= '0;
            out_q  <= '0;
        end else begin
            out_q <= out_d;
            if (cmd_accept) begin
                addr_q <= cmd_addr & ALIGN_MASK;
                rem_q  <= total_beats;
            end else if (ar_hs) begin
                addr_q <= addr_q + (ADDR_WIDTH'(burst_len) << SIZE);
                rem_q  <= rem_q - BTT_WIDTH'(burst_len);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    state_d = (cmd_btt == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = (out_d == '0) ? S_DONE : S_DRAIN;
                end else if (ar_hs && last_burst) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready     = (state_q == S_IDLE);
        busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done          = (state_q == S_DONE);
        m_axi_arvalid = (state_q == S_ISSUE) && !err_q &&
                        (out_q < OUT_W'(MAX_OUTSTANDING));
    end

endmodule

// File: tb/tb_dma_mm2s_burst_scheduler.sv
// Bench for dma_mm2s_burst_scheduler: randomized AR/R handshakes against a burst-list reference model.
module tb_dma_mm2s_burst_scheduler;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int BW      = 23;
    localparam int MBL     = 16;
    localparam int MAX_OUT = 2;
    localparam int BPB     = DW / 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [BW-1:0] cmd_btt = '0;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready = 1'b0;
    logic          rlast = 1'b0;
    logic [1:0]    rresp = 2'b00;
    logic          busy;
    logic          done;
    logic          err;

    dma_mm2s_burst_scheduler #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BTT_WIDTH       (BW),
        .MAX_BURST_LEN   (MBL),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_btt       (cmd_btt),
        .m_axi_araddr  (araddr),
        .m_axi_arlen   (arlen),
        .m_axi_arsize  (arsize),
        .m_axi_arburst (arburst),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .m_axi_rlast   (rlast),
        .m_axi_rresp   (rresp),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    burst_t exp_q[$];
    int     pend_q[$];
    int     out_cnt = 0;
    int     r_beat = 0;
    int     r_total = 0;
    logic   err_exp = 1'b0;
    int     n_tests = 0;
    int     n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected burst list straight from the splitting rules.
    task automatic plan_bursts(input logic [31:0] addr, input int btt);
        logic [31:0] a;
        int          beats;
        int          page;
        int          len;
        burst_t      b;
        a     = addr & 32'hFFFF_FFFC;
        beats = (btt + BPB - 1) / BPB;
        exp_q.delete();
        while (beats > 0) begin
            page = (4096 - int'(a % 4096)) / BPB;
            len  = beats;
            if (len > MBL)  len = MBL;
            if (len > page) len = page;
            b.addr = a;
            b.len  = len;
            exp_q.push_back(b);
            a     = a + 32'(len * BPB);
            beats = beats - len;
        end
    endtask

    task automatic run_cmd(input logic [31:0] addr, input int btt, input int ar_pct,
                           input int r_pct, input int rdy_pct, input int r_hold,
                           input int bad_beat);
        bit acc;
        bit fin;
        bit fin_seen;
        bit arv_exp;
        int cyc;
        acc      = 1'b0;
        fin_seen = 1'b0;
        cyc      = 0;
        cmd_addr  = addr;
        cmd_btt   = BW'(btt);
        cmd_valid = 1'b1;
        for (int n = 0; n < 8 && !acc; n++) begin
            @(negedge aclk);
            acc = cmd_ready;
            @(posedge aclk);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", 32'(acc), 32'd1);
        plan_bursts(addr, btt);
        err_exp = 1'b0;
        r_beat  = 0;
        r_total = 0;
        arready = ($urandom_range(99) < ar_pct);
        rready  = ($urandom_range(99) < rdy_pct);
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 2'b00;
        while (!fin_seen && cyc < 6000) begin
            @(negedge aclk);
            arv_exp = (exp_q.size() > 0) && (out_cnt < MAX_OUT);
            fin     = (exp_q.size() == 0) && (out_cnt == 0);
            check("arvalid", 32'(arvalid), 32'(arv_exp));
            if (arvalid && exp_q.size() > 0) begin
                check("araddr", araddr, exp_q[0].addr);
                check("arlen", 32'(arlen), 32'(exp_q[0].len - 1));
            end
            check("done", 32'(done), 32'(fin));
            check("busy", 32'(busy), 32'(!fin));
            check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            check("err", 32'(err), 32'(err_exp));
            if (arvalid && arready && exp_q.size() > 0) begin
                pend_q.push_back(exp_q[0].len);
                exp_q.delete(0);
                out_cnt++;
            end
            if (rvalid && rready) begin
`ifdef DMA_SCHED_RRESP_ERR_EN
                if (rresp[1]) begin
                    err_exp = 1'b1;
                    exp_q.delete();
                end
`endif
                r_total++;
                if (rlast) begin
                    pend_q.delete(0);
                    out_cnt--;
                    r_beat = 0;
                end else begin
                    r_beat++;
                end
            end
            fin_seen = fin;
            @(posedge aclk);
            #1;
            cyc++;
            arready = ($urandom_range(99) < ar_pct);
            rready  = ($urandom_range(99) < rdy_pct);
            if (cyc >= r_hold && pend_q.size() > 0 && $urandom_range(99) < r_pct) begin
                rvalid = 1'b1;
                rlast  = (r_beat == pend_q[0] - 1);
                rresp  = (r_total == bad_beat) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
        end
        check("done_seen", 32'(fin_seen), 32'd1);
        @(negedge aclk);
        check("ready_after_done", 32'(cmd_ready), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        @(posedge aclk);
        #1;
    endtask

    task automatic reset_mid_issue();
        cmd_addr  = 32'h0000_5000;
        cmd_btt   = 23'd512;
        cmd_valid = 1'b1;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rready    = 1'b0;
        rlast     = 1'b0;
        rresp     = 2'b00;
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        check("rst_pre_arvalid", 32'(arvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_q.delete();
        pend_q.delete();
        out_cnt = 0;
        // Stale R beats after release must not disturb the outstanding count.
        rvalid = 1'b1;
        rready = 1'b1;
        rlast  = 1'b1;
        repeat (2) begin
            @(negedge aclk);
            check("post_rst_ready", 32'(cmd_ready), 32'd1);
            check("post_rst_arvalid", 32'(arvalid), 32'd0);
            @(posedge aclk);
            #1;
        end
        rvalid = 1'b0;
        rready = 1'b0;
        rlast  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          b;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_arvalid", 32'(arvalid), 32'd0);
        check("reset_araddr", araddr, 32'd0);
        check("reset_arlen", 32'(arlen), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("arsize", 32'(arsize), 32'd2);
        check("arburst", 32'(arburst), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        run_cmd(32'h0000_1000, 64,   100, 100, 100, 0,  -1);
        run_cmd(32'h0000_0FF0, 64,   100, 100, 100, 0,  -1);
        run_cmd(32'h0000_2000, 1030, 100, 100, 100, 10, -1);
        run_cmd(32'h0000_3004, 0,    100, 100, 100, 0,  -1);
        run_cmd(32'h0000_1000, 256,  100, 100, 100, 6,  0);
        run_cmd(32'h0000_1003, 24,   70,  70,  70,  0,  -1);
        reset_mid_issue();
        run_cmd(32'h0000_4FC0, 200,  80,  80,  80,  0,  -1);

        for (int i = 0; i < 30; i++) begin
            a = $urandom & 32'h00FF_FFFF;
            if ($urandom_range(2) == 0) a[11:0] = 12'hFFF - 12'($urandom_range(127));
            if ($urandom_range(3) == 0) b = int'($urandom_range(8));
            else                        b = int'($urandom_range(600));
            run_cmd(a, b, 30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)),
                    30 + int'($urandom_range(70)), int'($urandom_range(4)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
